// File: rtl/fifo_pkg.sv
// Shared definitions for fifo_queue and later buffers built on it:
// width helpers and the valid/ready handshake pair.
package fifo_pkg;

    typedef struct packed {
        logic valid;
        logic ready;
    } hs_t;

    function automatic int clog2_depth(input int n);
        int r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // Pointers address DEPTH entries; a 2-entry queue still needs one bit.
    function automatic int ptr_width(input int depth);
        return (depth <= 2) ? 1 : clog2_depth(depth);
    endfunction

    function automatic logic fire(input hs_t hs);
        return hs.valid & hs.ready;
    endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Wrapping pointer for a circular buffer of DEPTH entries; DEPTH need not
// be a power of two, so the wrap is an explicit compare against DEPTH-1.
module fifo_ptr
    import fifo_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         inc,
    input  logic                         clr,
    output logic [ptr_width(DEPTH)-1:0]  ptr
);

    localparam int PTR_W = ptr_width(DEPTH);

    logic at_last;
    assign at_last = (ptr == PTR_W'(DEPTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (clr) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= at_last ? '0 : ptr + PTR_W'(1);
        end
    end

endmodule

// File: rtl/fifo_queue.sv
// Parametrised synchronous FIFO with valid/ready on both sides, occupancy,
// almost-full and flush. Define FIFO_BYPASS_EN for fall-through when empty.
module fifo_queue
    import fifo_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = DEPTH - 2
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              flush,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [WIDTH-1:0]                  in_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [WIDTH-1:0]                  out_data,
    output logic [clog2_depth(DEPTH+1)-1:0]   count,
    output logic                              almost_full,
    output logic                              empty,
    output logic                              full
);

    localparam int CNT_W = clog2_depth(DEPTH + 1);
    localparam int PTR_W = ptr_width(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             buf_empty;
    logic             passthru;
    logic             do_push;
    logic             do_pop;
    hs_t              in_hs;
    hs_t              out_hs;

    assign buf_empty   = (count == '0);
    assign empty       = buf_empty;
    assign full        = (count == CNT_W'(DEPTH));
    assign almost_full = (count >= CNT_W'(AF_LEVEL));

    // Ready never looks at out_ready: a full queue refuses even while popping.
    assign in_ready = ~full & ~flush;

`ifdef FIFO_BYPASS_EN
    assign out_valid = buf_empty ? (in_valid & ~flush) : 1'b1;
    assign out_data  = buf_empty ? in_data : mem[rd_ptr];
`else
    assign out_valid = ~buf_empty;
    assign out_data  = mem[rd_ptr];
`endif

    assign in_hs  = '{valid: in_valid,  ready: in_ready};
    assign out_hs = '{valid: out_valid, ready: out_ready};

    // A word taken while empty can only be a fall-through; it is never stored.
    assign passthru = buf_empty & fire(out_hs);
    assign do_push  = fire(in_hs) & ~passthru;
    assign do_pop   = fire(out_hs) & ~buf_empty & ~flush;

    fifo_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (do_push),
        .clr   (flush),
        .ptr   (wr_ptr)
    );

    fifo_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (do_pop),
        .clr   (flush),
        .ptr   (rd_ptr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (do_push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (flush) begin
            count <= '0;
        end else begin
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_queue.sv
// Scoreboard bench for fifo_queue (DEPTH=5, WIDTH=8, AF_LEVEL=3); the
// bypass checks follow FIFO_BYPASS_EN like the design does.
module tb_fifo_queue;

    localparam int WIDTH    = 8;
    localparam int DEPTH    = 5;
    localparam int AF_LEVEL = 3;
`ifdef FIFO_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic             clk;
    logic             rst_n;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [2:0]       count;
    logic             almost_full;
    logic             empty;
    logic             full;

    int checks   = 0;
    int failures = 0;
    int mcnt     = 0;
    logic [WIDTH-1:0] exp_q [$];

    fifo_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF_LEVEL)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .count       (count),
        .almost_full (almost_full),
        .empty       (empty),
        .full        (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every pop the DUT performs must match the oldest expected word.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready && !flush) begin
            if (exp_q.size() == 0) begin
                chk("pop_unexpected", 1, 0);
            end else begin
                chk("out_data", int'(out_data), int'(exp_q.pop_front()));
            end
        end
    end

    // One clock of stimulus; expected words go to the scoreboard on acceptance.
    task automatic step(input logic v, input logic [WIDTH-1:0] d,
                        input logic r, input logic f);
        bit acc;
        bit popx;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
        acc  = v && !f && (mcnt < DEPTH);
        popx = r && !f && ((mcnt > 0) || (BYP && v));
        if (acc) exp_q.push_back(d);
        @(negedge clk);
        chk("in_ready", int'(in_ready), int'(mcnt < DEPTH && !f));
        chk("out_valid", int'(out_valid), int'((mcnt > 0) || (BYP && v && !f)));
        @(posedge clk);
        #1;
        if (f) begin
            mcnt = 0;
            exp_q.delete();
        end else begin
            mcnt = mcnt + int'(acc) - int'(popx);
        end
        chk("count", int'(count), mcnt);
        chk("empty", int'(empty), int'(mcnt == 0));
        chk("full", int'(full), int'(mcnt == DEPTH));
        chk("almost_full", int'(almost_full), int'(mcnt >= AF_LEVEL));
    endtask

    task automatic idle_inputs();
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        flush     = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_count"}, int'(count), 0);
        chk({tag, "_empty"}, int'(empty), 1);
        chk({tag, "_full"}, int'(full), 0);
        chk({tag, "_af"}, int'(almost_full), 0);
        chk({tag, "_in_ready"}, int'(in_ready), 1);
        chk({tag, "_out_valid"}, int'(out_valid), 0);
        chk({tag, "_out_data"}, int'(out_data), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1 chk_reset_outputs("rst");
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Fill to full, refuse a sixth word, then drain in order.
        for (int i = 1; i <= 5; i++) step(1'b1, WIDTH'(i * 8'h11), 1'b0, 1'b0);
        chk("fill_full", int'(full), 1);
        chk("fill_in_ready", int'(in_ready), 0);
        step(1'b1, 8'h66, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("drain_empty", int'(empty), 1);

        // Continuous streaming across pointer wrap with two words resident.
        step(1'b1, 8'hA0, 1'b0, 1'b0);
        step(1'b1, 8'hA1, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) step(1'b1, WIDTH'(8'hB0 + i), 1'b1, 1'b0);
        chk("stream_count", int'(count), 2);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);

        // Full with a simultaneous pop: the push waits one cycle.
        for (int i = 0; i < 5; i++) step(1'b1, WIDTH'(8'hC0 + i), 1'b0, 1'b0);
        step(1'b1, 8'hC5, 1'b1, 1'b0);
        chk("full_pop_count", int'(count), 4);
        step(1'b1, 8'hC5, 1'b0, 1'b0);
        chk("full_repush_count", int'(count), 5);
        for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

        // Flush wins over push and pop at the same edge.
        for (int i = 0; i < 3; i++) step(1'b1, WIDTH'(8'hD0 + i), 1'b0, 1'b0);
        step(1'b1, 8'hEE, 1'b1, 1'b1);
        chk("flush_count", int'(count), 0);
        step(1'b1, 8'hAB, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);

        // Asynchronous reset between edges with four words resident.
        for (int i = 0; i < 4; i++) step(1'b1, WIDTH'(8'hE0 + i), 1'b0, 1'b0);
        chk("pre_reset_count", int'(count), 4);
        idle_inputs();
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("async");
        exp_q.delete();
        mcnt = 0;
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Empty queue with a word offered and the consumer ready.
        in_valid  = 1'b1;
        in_data   = 8'h5A;
        out_ready = 1'b1;
        #1;
`ifdef FIFO_BYPASS_EN
        chk("bypass_out_valid", int'(out_valid), 1);
        chk("bypass_out_data", int'(out_data), 8'h5A);
        step(1'b1, 8'h5A, 1'b1, 1'b0);
        chk("bypass_count", int'(count), 0);
`else
        chk("nobypass_out_valid", int'(out_valid), 0);
        step(1'b1, 8'h5A, 1'b1, 1'b0);
        chk("nobypass_count", int'(count), 1);
        step(1'b0, 8'h00, 1'b1, 1'b0);
`endif
        idle_inputs();
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
